// File: rtl/mole_round_ctrl.sv
// Round sequencer for the whack-a-mole game: spawn, settle, show, score, gap.
// Optional MOLE_SPEEDUP_EN shrinks the visible window by SPEEDUP_STEP per hit, floored at MIN_VISIBLE.
module mole_round_ctrl #(
  parameter int VISIBLE_CYCLES = 50_000_000,
  parameter int GAP_CYCLES     = 25_000_000,
  parameter int NUM_ROUNDS     = 20,
  parameter int SETTLE_CYCLES  = 2,
  parameter int SPEEDUP_STEP   = 2_000_000,
  parameter int MIN_VISIBLE    = 10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [17:0] hit_btn,
  input  logic [4:0]  mole_pos,
  output logic        spawn_trigger,
  output logic        mole_enable,
  output logic        hit_pulse,
  output logic [7:0]  score,
  output logic [7:0]  miss_count,
  output logic [7:0]  round_num,
  output logic        busy,
  output logic        done
);

  localparam int T_MAX_A = (VISIBLE_CYCLES > GAP_CYCLES) ? VISIBLE_CYCLES : GAP_CYCLES;
  localparam int T_MAX   = (T_MAX_A > SETTLE_CYCLES) ? T_MAX_A : SETTLE_CYCLES;
  localparam int TW      = $clog2(T_MAX) + 1;

  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [TW-1:0] T_VIS    = TW'(VISIBLE_CYCLES);
  localparam logic [TW-1:0] T_GAP    = TW'(GAP_CYCLES);
  localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CYCLES);
  localparam logic [7:0]    ROUNDS_LAST = 8'(NUM_ROUNDS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SPAWN  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] SHOW   = 3'd3;
  localparam logic [2:0] GAP    = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]    state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [4:0]    tgt_r, tgt_s;
  logic [7:0]    score_r, score_s;
  logic [7:0]    miss_r, miss_s;
  logic [7:0]    round_r, round_s;
  logic          hit_pulse_r, hit_pulse_s;
  logic          spawn_r, mole_en_r, busy_r, done_r;
  logic          start_q_r;
  logic [17:0]   hit_q_r;
  logic          start_rise_s;
  logic [17:0]   hit_rise_s;
  logic          tgt_hit_s;
  logic [TW-1:0] win_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign start_rise_s = start & ~start_q_r;
  assign hit_rise_s   = hit_btn & ~hit_q_r;
  // Illegal target positions can never be hit.
  assign tgt_hit_s    = (tgt_r <= 5'd17) ? hit_rise_s[tgt_r] : 1'b0;

`ifdef MOLE_SPEEDUP_EN
  localparam logic [TW-1:0] T_STEP  = TW'(SPEEDUP_STEP);
  localparam logic [TW-1:0] T_MIN   = TW'(MIN_VISIBLE);
  localparam logic [TW-1:0] T_FLOOR = TW'(MIN_VISIBLE + SPEEDUP_STEP);

  logic [TW-1:0] window_r;
  logic          game_start_s;

  function automatic logic [TW-1:0] shrink(input logic [TW-1:0] w);
    return (w >= T_FLOOR) ? w - T_STEP : T_MIN;
  endfunction

  assign game_start_s = (state_s == SPAWN) && ((state_r == IDLE) || (state_r == DONE));
  assign win_s        = window_r;

  // Window reloads at game start and shrinks after every scored hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      window_r <= T_VIS;
    end else if (game_start_s) begin
      window_r <= T_VIS;
    end else if (hit_pulse_s) begin
      window_r <= shrink(window_r);
    end else begin
      window_r <= window_r;
    end
  end
`else
  logic unused_params_s;
  assign unused_params_s = ^{SPEEDUP_STEP, MIN_VISIBLE};
  assign win_s           = T_VIS;
`endif

  // Next-state and counter logic; abort overrides every transition.
  always_comb begin
    state_s     = state_r;
    timer_s     = timer_r;
    tgt_s       = tgt_r;
    score_s     = score_r;
    miss_s      = miss_r;
    round_s     = round_r;
    hit_pulse_s = 1'b0;
    if (abort) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start_rise_s) begin
            score_s = 8'd0;
            miss_s  = 8'd0;
            round_s = 8'd1;
            state_s = SPAWN;
          end else begin
            state_s = state_r;
          end
        end
        SPAWN: begin
          timer_s = T_SETTLE;
          state_s = SETTLE;
        end
        SETTLE: begin
          if (timer_r <= T_ONE) begin
            tgt_s   = mole_pos;
            timer_s = win_s;
            state_s = SHOW;
          end else begin
            timer_s = timer_r - T_ONE;
          end
        end
        SHOW: begin
          // A hit on the final visible cycle still wins over the timeout.
          if (tgt_hit_s) begin
            score_s     = sat_inc(score_r);
            hit_pulse_s = 1'b1;
            timer_s     = T_GAP;
            state_s     = GAP;
          end else if (timer_r <= T_ONE) begin
            miss_s  = sat_inc(miss_r);
            timer_s = T_GAP;
            state_s = GAP;
          end else begin
            timer_s = timer_r - T_ONE;
          end
        end
        GAP: begin
          if (timer_r <= T_ONE) begin
            if (round_r == ROUNDS_LAST) begin
              state_s = DONE;
            end else begin
              round_s = round_r + 8'd1;
              state_s = SPAWN;
            end
          end else begin
            timer_s = timer_r - T_ONE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, counters, edge-detect history and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      timer_r     <= '0;
      tgt_r       <= 5'd0;
      score_r     <= 8'd0;
      miss_r      <= 8'd0;
      round_r     <= 8'd0;
      hit_pulse_r <= 1'b0;
      spawn_r     <= 1'b0;
      mole_en_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      start_q_r   <= 1'b0;
      hit_q_r     <= 18'd0;
    end else begin
      state_r     <= state_s;
      timer_r     <= timer_s;
      tgt_r       <= tgt_s;
      score_r     <= score_s;
      miss_r      <= miss_s;
      round_r     <= round_s;
      hit_pulse_r <= hit_pulse_s;
      spawn_r     <= (state_s == SPAWN);
      mole_en_r   <= (state_s == SHOW);
      busy_r      <= (state_s != IDLE) && (state_s != DONE);
      done_r      <= (state_s == DONE);
      start_q_r   <= start;
      hit_q_r     <= hit_btn;
    end
  end

  assign spawn_trigger = spawn_r;
  assign mole_enable   = mole_en_r;
  assign hit_pulse     = hit_pulse_r;
  assign score         = score_r;
  assign miss_count    = miss_r;
  assign round_num     = round_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: doc/mole_round_ctrl.md
Name: mole_round_ctrl

Overview:
- Game sequencer for the whack-a-mole datapath; sits above the random mole picker (rng + mole decoder + trigger capture).
- Runs a fixed number of rounds per game. Each round it pulses the picker's trigger, waits for the new position to settle, and shows the mole for a timed window.
- It edge-detects player buttons to score hits and misses, then inserts a gap before the next round.
- Outputs score, round and status for the seven-segment and LED drivers.

Parameters:
- VISIBLE_CYCLES, 50_000_000: mole-visible window in clk cycles (1 s at 50 MHz).
- GAP_CYCLES, 25_000_000: blank time between rounds.
- NUM_ROUNDS, 20: rounds per game (1..255).
- SETTLE_CYCLES, 2: cycles from trigger pulse until the picker's position/displayL are valid.
- SPEEDUP_STEP, 2_000_000: window reduction per hit (optional feature only).
- MIN_VISIBLE, 10_000_000: floor on the window (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; a rising edge in IDLE or DONE starts a game
- abort  in  1  level; forces IDLE, keeps counters
- hit_btn  in  18  one bit per mole position, already debounced
- mole_pos  in  5  position from picker, 0..17
- spawn_trigger  out  1  one-cycle pulse to picker trigger
- mole_enable  out  1  high only in SHOW; gates displayL onto LEDs
- hit_pulse  out  1  one cycle on a scored hit
- score  out  8  hits this game, saturating at 255
- miss_count  out  8  misses this game, saturating at 255
- round_num  out  8  current round, 1-based; 0 in IDLE after reset
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE

Behaviour:
- All outputs are registered. On reset: state=IDLE, all outputs 0, timer=0, start/hit_btn edge registers cleared.
- Edge detection: start_q and hit_q are 1-cycle delayed copies. rise = in & ~q.
- States:
  - IDLE: on start rise, clear score/miss_count, set round_num=1 → SPAWN.
  - SPAWN: spawn_trigger=1 for exactly this cycle, timer=SETTLE_CYCLES → SETTLE.
  - SETTLE: timer decrements. At 0, latch mole_pos into tgt, timer=window, mole_enable=1 → SHOW.
  - SHOW, hit: hit_rise[tgt]=1 and tgt≤17 → score+1, hit_pulse=1 → GAP.
  - SHOW, timeout: timer reaches 0 with no hit → miss_count+1 → GAP.
  - SHOW, priority: a hit in the same cycle as the timeout counts as a hit.
  - SHOW, other presses: rising edges on bits other than tgt are ignored. Multiple simultaneous bits including tgt count as a hit.
  - GAP: mole_enable=0, timer=GAP_CYCLES, count down. At 0: if round_num==NUM_ROUNDS → DONE, else round_num+1 → SPAWN.
  - DONE: done=1, counters held. A start rise restarts as from IDLE.
- Timing: mole_enable is high for exactly window cycles unless cut short by a hit. Trigger-to-SHOW latency = SETTLE_CYCLES+1 cycles.
- Rising edges on hit_btn are evaluated only in SHOW; presses held across the SHOW entry do not count.
- tgt>17 (illegal) can never hit; the round resolves as a miss on timeout.
- A start rise while busy is ignored.
- abort has priority over all transitions. → IDLE next cycle, mole_enable=0, spawn_trigger=0, score/miss_count/round_num held.
- Reset mid-game overrides everything and returns to the reset values.
- Timer width is $clog2 of the maximum of VISIBLE_CYCLES, GAP_CYCLES and SETTLE_CYCLES, plus 1.

Optional Feature:
- Macro: MOLE_SPEEDUP_EN.
- Defined: a window register is loaded with VISIBLE_CYCLES at game start. Each hit reduces it by SPEEDUP_STEP, clamped at MIN_VISIBLE; the new value applies from the next SHOW. Misses leave it unchanged.
- Not defined: window is the constant VISIBLE_CYCLES, and the SPEEDUP_STEP and MIN_VISIBLE parameters are unused.

Test Plan (VISIBLE_CYCLES=10, GAP_CYCLES=4, NUM_ROUNDS=3, SETTLE_CYCLES=2):
- Start, no presses → per round: spawn_trigger 1 cycle, mole_enable high exactly 10 cycles. After round 3 GAP: done=1, miss_count=3, score=0, round_num=3.
- Model picker returns mole_pos=5; press hit_btn[5] on SHOW cycle 4 → hit_pulse 1 cycle, score=1, mole_enable drops next cycle, GAP begins.
- Press hit_btn[9] with tgt=5 → no score. Timeout → miss_count=1. Press hit_btn[5] on the final SHOW cycle → score=1, miss_count unchanged.
- hit_btn[5] held high from before SHOW entry with tgt=5 → no hit; round ends as a miss.
- abort asserted in SHOW with score=1 → IDLE next cycle, mole_enable=0, busy=0, score=1. A start rise then clears score=0 and sets round_num=1.
- With MOLE_SPEEDUP_EN, SPEEDUP_STEP=3, MIN_VISIBLE=5: three consecutive hits give windows 10, 7, 5 (clamped). Synchronous reset mid-SHOW → all outputs 0 next cycle.
